axi_lite_mem_master: RTL and testbench
======================================

Name: axi_lite_mem_master

Overview:
- Bridges the CPU-side memory request port (valid/wen/ren/addr/wdata/wmask) onto an AXI-lite master interface.
- It is the initiator end of the AXI_ift link whose slave end is the RAM/DDR model.
- One transaction in flight at a time. Write and read FSMs are separate, each with its state exported for debug.

Parameters:
- C_M_AXI_ADDR_WIDTH, 64, address width of the request port and the AXI AW/AR channels.
- C_M_AXI_DATA_WIDTH, 64, data width of the request port and the AXI W/R channels. Strobe width is C_M_AXI_DATA_WIDTH/8.

Ports:
- clk  input  1  system clock; every register samples on the rising edge.
- rstn  input  1  reset; asynchronous assert, active-low.
- master_ift  AXI_ift.Master  -  AXI-lite master. Signals used: aw_addr, aw_valid, aw_ready, w_data, w_strb, w_valid, w_ready, b_resp, b_valid, b_ready, ar_addr, ar_valid, ar_ready, r_data, r_resp, r_valid, r_ready.
- mem_valid  input  1  request present; held stable until mem_ready.
- mem_wen  input  1  write request.
- mem_ren  input  1  read request.
- mem_addr  input  ADDR_WIDTH  byte address.
- mem_wdata  input  DATA_WIDTH  write data.
- mem_wmask  input  DATA_WIDTH/8  byte enables.
- mem_ready  output  1  one-cycle completion pulse.
- mem_rdata  output  DATA_WIDTH  read data; valid while mem_ready is high on a read.
- mem_error  output  1  response was non-OKAY; qualified by mem_ready.
- debug_axi_wstate  output  2  write FSM state encoding.
- debug_axi_rstate  output  2  read FSM state encoding.

Behaviour:
- Reset (rstn=0, asynchronous):
  - Both FSMs go to IDLE.
  - All valid/ready outputs and mem_ready/mem_error = 0.
  - mem_rdata = 0, addr/data/strb registers = 0.
  - Reset mid-transaction abandons it with no completion pulse; the slave is expected to be reset with us.
- Request acceptance: in IDLE, mem_valid=1 with mem_wen=1 starts a write.
  - Otherwise mem_valid=1 with mem_ren=1 starts a read.
  - If wen and ren are both 1, write wins and ren is ignored for that request.
  - mem_valid=1 with neither set is ignored.
  - addr, wdata and wmask are captured into registers at acceptance.
- Write FSM states: W_IDLE=0, W_REQ=1, W_RESP=2.
  - W_IDLE -> W_REQ on acceptance; aw_valid=1 and w_valid=1 from the next cycle.
  - W_REQ: aw_valid drops the cycle after the aw_valid&aw_ready handshake. w_valid drops the cycle after the w_valid&w_ready handshake.
  - The two handshakes may occur in the same or different cycles, in either order. A done flag is tracked per channel.
  - Move to W_RESP once both handshakes have occurred. b_ready=1 in W_RESP.
  - W_RESP: on b_valid, go to W_IDLE. Pulse mem_ready the next cycle, with mem_error = (b_resp != 2'b00).
- Read FSM states: R_IDLE=0, R_ADDR=1, R_DATA=2.
  - R_ADDR: ar_valid=1. On ar_ready, go to R_DATA with r_ready=1.
  - R_DATA: on r_valid, register r_data into mem_rdata and go to R_IDLE. Pulse mem_ready the next cycle, with mem_error = (r_resp != 2'b00).
- Single outstanding request:
  - While either FSM is non-IDLE, or during the cycle mem_ready is asserted, no new request is accepted.
  - The requester must deassert or change mem_valid by the cycle after mem_ready; a still-high mem_valid then starts a new transaction.
- Latency, zero-wait slave:
  - Write: accept at cycle 0, AW/W handshake at 1, B at 2, mem_ready at 3.
  - Read: accept at 0, AR at 1, R at 2, mem_ready at 3.
- AXI rules:
  - Once valid is asserted it is held, with stable payload, until the handshake.
  - valid never depends on ready.
  - aw_addr and ar_addr carry the full mem_addr, with no alignment.
  - AxPROT, if present in AXI_ift, is tied to 0.
- mem_rdata holds its last read value until the next read completes.

Decomposition:
- Shared package axi_lite_pkg:
  - typedef enum of write states and typedef enum of read states, each 2 bits.
  - localparams RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
- No sub-module. The two FSMs plus the request latch live in one module.

Test Plan:
- Zero-wait write, addr=64'h8000_0010, wdata=64'hDEAD_BEEF_0123_4567, wmask=8'hFF -> one AW/W handshake, mem_ready at cycle 3, mem_error=0, slave memory holds the data.
- Read back of the same address -> mem_rdata=64'hDEAD_BEEF_0123_4567 with a 1-cycle mem_ready, mem_error=0.
- Slave delays w_ready by 3 cycles after aw_ready -> aw_valid drops after 1 cycle, w_valid held with stable data for 4 cycles, exactly one completion pulse.
- mem_wen=mem_ren=1 with wmask=8'h0F -> only a write occurs, w_strb=8'h0F, ar_valid never asserts.
- Slave returns r_resp=2'b10 -> mem_ready with mem_error=1; the next OKAY read clears mem_error.
- rstn pulsed low while in W_RESP -> outputs are 0 asynchronously, no mem_ready, and debug_axi_wstate=0 after release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types and response codes for the AXI-lite memory master.
`timescale 1ns/1ps
package axi_lite_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rstate_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_if.sv
// AXI-lite link between a memory master and the RAM/DDR slave model.
`timescale 1ns/1ps
interface AXI_ift #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic                    aw_valid;
  logic                    aw_ready;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_valid;
  logic                    w_ready;
  logic [1:0]              b_resp;
  logic                    b_valid;
  logic                    b_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic                    ar_valid;
  logic                    ar_ready;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_valid;
  logic                    r_ready;

  modport Master (
    output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );

  modport Slave (
    input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready, ar_addr, ar_valid, r_ready,
    output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
  );
endinterface

// File: rtl/axi_lite_mem_master.sv
// CPU memory request port to AXI-lite master bridge; one transaction in flight,
// separate write and read FSMs sharing a single request latch.
`timescale 1ns/1ps
module axi_lite_mem_master
  import axi_lite_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 64
) (
  input  logic                            clk,
  input  logic                            rstn,
  AXI_ift.Master                          master_ift,
  input  logic                            mem_valid,
  input  logic                            mem_wen,
  input  logic                            mem_ren,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   mem_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   mem_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] mem_wmask,
  output logic                            mem_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   mem_rdata,
  output logic                            mem_error,
  output logic [1:0]                      debug_axi_wstate,
  output logic [1:0]                      debug_axi_rstate
);

  localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

  wstate_e                         r_wstate;
  rstate_e                         r_rstate;
  logic                            r_aw_valid;
  logic                            r_w_valid;
  logic                            r_b_ready;
  logic                            r_aw_done;
  logic                            r_w_done;
  logic                            r_ar_valid;
  logic                            r_r_ready;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_addr;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic [STRB_W-1:0]               r_wstrb;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_rdata;
  logic                            r_mem_ready;
  logic                            r_mem_error;

  logic w_accept;
  logic w_start_wr;
  logic w_start_rd;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_aw_done_nxt;
  logic w_w_done_nxt;
  logic w_wr_done;
  logic w_rd_done;

  // The completion-pulse cycle is also blocked so a held mem_valid cannot re-issue early.
  assign w_accept      = mem_valid && (r_wstate == W_IDLE) && (r_rstate == R_IDLE) && !r_mem_ready;
  assign w_start_wr    = w_accept && mem_wen;
  assign w_start_rd    = w_accept && !mem_wen && mem_ren;
  assign w_aw_hs       = r_aw_valid && master_ift.aw_ready;
  assign w_w_hs        = r_w_valid && master_ift.w_ready;
  assign w_aw_done_nxt = r_aw_done || w_aw_hs;
  assign w_w_done_nxt  = r_w_done || w_w_hs;
  assign w_wr_done     = (r_wstate == W_RESP) && master_ift.b_valid;
  assign w_rd_done     = (r_rstate == R_DATA) && master_ift.r_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else if (w_start_wr || w_start_rd) begin
      r_addr  <= mem_addr;
      r_wdata <= mem_wdata;
      r_wstrb <= mem_wmask;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wstate   <= W_IDLE;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_b_ready  <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_start_wr) begin
            r_wstate   <= W_REQ;
            r_aw_valid <= 1'b1;
            r_w_valid  <= 1'b1;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
          end
        end
        W_REQ: begin
          // AW and W complete independently; B is awaited only once both are done.
          if (w_aw_hs) begin
            r_aw_valid <= 1'b0;
            r_aw_done  <= 1'b1;
          end
          if (w_w_hs) begin
            r_w_valid <= 1'b0;
            r_w_done  <= 1'b1;
          end
          if (w_aw_done_nxt && w_w_done_nxt) begin
            r_wstate  <= W_RESP;
            r_b_ready <= 1'b1;
          end
        end
        W_RESP: begin
          if (master_ift.b_valid) begin
            r_wstate  <= W_IDLE;
            r_b_ready <= 1'b0;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rstate   <= R_IDLE;
      r_ar_valid <= 1'b0;
      r_r_ready  <= 1'b0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_start_rd) begin
            r_rstate   <= R_ADDR;
            r_ar_valid <= 1'b1;
          end
        end
        R_ADDR: begin
          if (master_ift.ar_ready) begin
            r_rstate   <= R_DATA;
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
          end
        end
        R_DATA: begin
          if (master_ift.r_valid) begin
            r_rstate  <= R_IDLE;
            r_r_ready <= 1'b0;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_mem_ready <= 1'b0;
      r_mem_error <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_mem_ready <= w_wr_done || w_rd_done;
      r_mem_error <= (w_wr_done && resp_is_error(master_ift.b_resp)) ||
                     (w_rd_done && resp_is_error(master_ift.r_resp));
      if (w_rd_done) begin
        r_rdata <= master_ift.r_data;
      end
    end
  end

  assign master_ift.aw_addr  = r_addr;
  assign master_ift.aw_valid = r_aw_valid;
  assign master_ift.w_data   = r_wdata;
  assign master_ift.w_strb   = r_wstrb;
  assign master_ift.w_valid  = r_w_valid;
  assign master_ift.b_ready  = r_b_ready;
  assign master_ift.ar_addr  = r_addr;
  assign master_ift.ar_valid = r_ar_valid;
  assign master_ift.r_ready  = r_r_ready;

  assign mem_ready        = r_mem_ready;
  assign mem_rdata        = r_rdata;
  assign mem_error        = r_mem_error;
  assign debug_axi_wstate = r_wstate;
  assign debug_axi_rstate = r_rstate;

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Bench for axi_lite_mem_master: behavioural AXI-lite slave with programmable
// stalls and responses, plus a byte-masked reference memory for expected reads.
`timescale 1ns/1ps
module tb_axi_lite_mem_master;
  import axi_lite_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_wen = 1'b0;
  logic        mem_ren = 1'b0;
  logic [63:0] mem_addr = '0;
  logic [63:0] mem_wdata = '0;
  logic [7:0]  mem_wmask = '0;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic        mem_error;
  logic [1:0]  debug_axi_wstate;
  logic [1:0]  debug_axi_rstate;

  AXI_ift #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) axi ();

  axi_lite_mem_master #(
    .C_M_AXI_ADDR_WIDTH(64),
    .C_M_AXI_DATA_WIDTH(64)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .master_ift       (axi),
    .mem_valid        (mem_valid),
    .mem_wen          (mem_wen),
    .mem_ren          (mem_ren),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_wmask        (mem_wmask),
    .mem_ready        (mem_ready),
    .mem_rdata        (mem_rdata),
    .mem_error        (mem_error),
    .debug_axi_wstate (debug_axi_wstate),
    .debug_axi_rstate (debug_axi_rstate)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Slave configuration, set by the stimulus before each transaction
  int         cfg_aw_dly = 0, cfg_w_dly = 0, cfg_ar_dly = 0, cfg_b_dly = 0, cfg_r_dly = 0;
  logic [1:0] cfg_bresp = RESP_OKAY, cfg_rresp = RESP_OKAY;

  // Slave state and monitor counters
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  logic [63:0] smem [logic [63:0]];
  logic        aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0;
  logic [63:0] aw_addr_q = '0, w_data_q = '0, ar_addr_q = '0;
  logic [7:0]  w_strb_q = '0;
  logic        last_w_pend = 1'b0;
  logic [63:0] last_w_data = '0;
  int n_aw_hs = 0, n_w_hs = 0, n_b_hs = 0, n_ar_hs = 0, n_r_hs = 0;
  int n_aw_vcyc = 0, n_w_vcyc = 0, n_ar_vcyc = 0, n_ready = 0, n_unstable = 0;

  logic [63:0] model_mem [logic [63:0]];

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] strb);
    logic [63:0] res;
    res = old;
    for (int b = 0; b < 8; b++) if (strb[b]) res[b*8 +: 8] = nw[b*8 +: 8];
    return res;
  endfunction

  function automatic logic [63:0] slave_rd(input logic [63:0] a);
    return smem.exists(a) ? smem[a] : 64'h0;
  endfunction

  function automatic logic [63:0] model_rd(input logic [63:0] a);
    return model_mem.exists(a) ? model_mem[a] : 64'h0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_got      <= 1'b0;
      w_got       <= 1'b0;
      ar_got      <= 1'b0;
      last_w_pend <= 1'b0;
    end else begin
      if (axi.aw_valid) n_aw_vcyc <= n_aw_vcyc + 1;
      if (axi.w_valid)  n_w_vcyc  <= n_w_vcyc + 1;
      if (axi.ar_valid) n_ar_vcyc <= n_ar_vcyc + 1;
      if (mem_ready)    n_ready   <= n_ready + 1;
      if (axi.w_valid && last_w_pend && (axi.w_data !== last_w_data)) n_unstable <= n_unstable + 1;
      last_w_pend <= axi.w_valid && !axi.w_ready;
      last_w_data <= axi.w_data;
      if (axi.aw_valid && axi.aw_ready) begin
        aw_got    <= 1'b1;
        aw_addr_q <= axi.aw_addr;
        n_aw_hs   <= n_aw_hs + 1;
      end
      if (axi.w_valid && axi.w_ready) begin
        w_got    <= 1'b1;
        w_data_q <= axi.w_data;
        w_strb_q <= axi.w_strb;
        n_w_hs   <= n_w_hs + 1;
      end
      if (axi.b_valid && axi.b_ready) begin
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        n_b_hs <= n_b_hs + 1;
        smem[aw_addr_q] = merge(slave_rd(aw_addr_q), w_data_q, w_strb_q);
      end
      if (axi.ar_valid && axi.ar_ready) begin
        ar_got    <= 1'b1;
        ar_addr_q <= axi.ar_addr;
        n_ar_hs   <= n_ar_hs + 1;
      end
      if (axi.r_valid && axi.r_ready) begin
        ar_got <= 1'b0;
        n_r_hs <= n_r_hs + 1;
      end
    end
  end

  // Slave drives its outputs on the falling edge so the DUT samples settled values.
  always @(negedge clk) begin
    if (!rstn) begin
      axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
      axi.b_valid  = 1'b0; axi.b_resp  = 2'b00;
      axi.r_valid  = 1'b0; axi.r_resp  = 2'b00; axi.r_data = '0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
    end else begin
      if (axi.aw_valid) begin axi.aw_ready = (aw_wait >= cfg_aw_dly); aw_wait++; end
      else begin axi.aw_ready = 1'b0; aw_wait = 0; end
      if (axi.w_valid) begin axi.w_ready = (w_wait >= cfg_w_dly); w_wait++; end
      else begin axi.w_ready = 1'b0; w_wait = 0; end
      if (axi.ar_valid) begin axi.ar_ready = (ar_wait >= cfg_ar_dly); ar_wait++; end
      else begin axi.ar_ready = 1'b0; ar_wait = 0; end
      if (aw_got && w_got) begin
        axi.b_valid = (b_wait >= cfg_b_dly); b_wait++; axi.b_resp = cfg_bresp;
      end else begin
        axi.b_valid = 1'b0; b_wait = 0; axi.b_resp = 2'b00;
      end
      if (ar_got) begin
        axi.r_valid = (r_wait >= cfg_r_dly); r_wait++;
        axi.r_resp = cfg_rresp; axi.r_data = slave_rd(ar_addr_q);
      end else begin
        axi.r_valid = 1'b0; r_wait = 0; axi.r_resp = 2'b00; axi.r_data = '0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_slave(input int awd, input int wd, input int ard, input int bd, input int rd,
                           input logic [1:0] br, input logic [1:0] rr);
    cfg_aw_dly = awd; cfg_w_dly = wd; cfg_ar_dly = ard; cfg_b_dly = bd; cfg_r_dly = rd;
    cfg_bresp = br; cfg_rresp = rr;
  endtask

  task automatic wait_done(output int lat, output logic done, output logic err,
                           output logic [63:0] rd);
    lat = 0; done = 1'b0; err = 1'b0; rd = '0;
    for (int i = 0; i < 64; i++) begin
      if (!done) begin
        @(posedge clk); #1;
        lat++;
        if (mem_ready) begin done = 1'b1; err = mem_error; rd = mem_rdata; end
      end
    end
    mem_valid = 1'b0; mem_wen = 1'b0; mem_ren = 1'b0;
    @(posedge clk); #1;
    check("ready_single_pulse", {63'd0, mem_ready}, 64'd0);
  endtask

  task automatic do_write(input string tag, input logic [63:0] a, input logic [63:0] d,
                          input logic [7:0] m, input logic also_ren, input logic zero_wait);
    int s_aw, s_w, s_ar, s_rdy, lat;
    logic done, err;
    logic [63:0] rd;
    logic exp_err;
    s_aw = n_aw_hs; s_w = n_w_hs; s_ar = n_ar_vcyc; s_rdy = n_ready;
    exp_err = (cfg_bresp != RESP_OKAY);
    mem_valid = 1'b1; mem_wen = 1'b1; mem_ren = also_ren;
    mem_addr = a; mem_wdata = d; mem_wmask = m;
    wait_done(lat, done, err, rd);
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_error"}, {63'd0, err}, {63'd0, exp_err});
    if (zero_wait) check({tag, "_latency"}, 64'(lat), 64'd3);
    check({tag, "_aw_count"}, 64'(n_aw_hs - s_aw), 64'd1);
    check({tag, "_w_count"}, 64'(n_w_hs - s_w), 64'd1);
    check({tag, "_no_ar"}, 64'(n_ar_vcyc - s_ar), 64'd0);
    check({tag, "_pulses"}, 64'(n_ready - s_rdy), 64'd1);
    check({tag, "_awaddr"}, aw_addr_q, a);
    check({tag, "_wstrb"}, {56'd0, w_strb_q}, {56'd0, m});
    if (done) model_mem[a] = merge(model_rd(a), d, m);
  endtask

  task automatic do_read(input string tag, input logic [63:0] a, input logic zero_wait,
                         output logic [63:0] got);
    int s_ar, s_aw, s_rdy, lat;
    logic done, err;
    logic exp_err;
    s_ar = n_ar_hs; s_aw = n_aw_vcyc; s_rdy = n_ready;
    exp_err = (cfg_rresp != RESP_OKAY);
    mem_valid = 1'b1; mem_wen = 1'b0; mem_ren = 1'b1;
    mem_addr = a; mem_wdata = {$urandom, $urandom}; mem_wmask = 8'($urandom);
    wait_done(lat, done, err, got);
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_error"}, {63'd0, err}, {63'd0, exp_err});
    check({tag, "_rdata"}, got, model_rd(a));
    if (zero_wait) check({tag, "_latency"}, 64'(lat), 64'd3);
    check({tag, "_ar_count"}, 64'(n_ar_hs - s_ar), 64'd1);
    check({tag, "_no_aw"}, 64'(n_aw_vcyc - s_aw), 64'd0);
    check({tag, "_pulses"}, 64'(n_ready - s_rdy), 64'd1);
    check({tag, "_araddr"}, ar_addr_q, a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] addrs [4];
    logic [63:0] rd, last_rd;
    int s_aw_v, s_w_v, s_unst, s_rdy, s_v, op, awd, wd, ard, bd, rdl;
    logic reached;
    logic [1:0] resp;
    addrs[0] = 64'h8000_0010; addrs[1] = 64'h8000_0018;
    addrs[2] = 64'h8000_0003; addrs[3] = 64'h0000_1000_0000_0040;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
    check("rst_mem_error", {63'd0, mem_error}, 64'd0);
    check("rst_mem_rdata", mem_rdata, 64'd0);
    check("rst_valids", {59'd0, axi.aw_valid, axi.w_valid, axi.b_ready, axi.ar_valid, axi.r_ready}, 64'd0);
    check("rst_states", {60'd0, debug_axi_wstate, debug_axi_rstate}, 64'd0);
    check("rst_addr_data", axi.aw_addr | axi.w_data | {56'd0, axi.w_strb}, 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Zero-wait write and read-back
    set_slave(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY);
    do_write("wr_basic", 64'h8000_0010, 64'hDEAD_BEEF_0123_4567, 8'hFF, 1'b0, 1'b1);
    do_read("rd_basic", 64'h8000_0010, 1'b1, rd);

    // W channel stalled three cycles beyond AW
    set_slave(0, 3, 0, 0, 0, RESP_OKAY, RESP_OKAY);
    s_aw_v = n_aw_vcyc; s_w_v = n_w_vcyc; s_unst = n_unstable;
    do_write("wr_wstall", 64'h8000_0018, 64'h0F1E_2D3C_4B5A_6978, 8'hFF, 1'b0, 1'b0);
    check("wstall_aw_cycles", 64'(n_aw_vcyc - s_aw_v), 64'd1);
    check("wstall_w_cycles", 64'(n_w_vcyc - s_w_v), 64'd4);
    check("wstall_w_stable", 64'(n_unstable - s_unst), 64'd0);

    // Write wins when both wen and ren are set
    set_slave(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY);
    do_write("wr_both", 64'h8000_0010, 64'h1111_1111_1111_1111, 8'h0F, 1'b1, 1'b1);
    do_read("rd_merged", 64'h8000_0010, 1'b1, rd);
    check("merged_value", rd, 64'hDEAD_BEEF_1111_1111);

    // Error response then clean read
    set_slave(0, 0, 0, 0, 0, RESP_OKAY, RESP_SLVERR);
    do_read("rd_slverr", 64'h8000_0018, 1'b1, rd);
    set_slave(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY);
    do_read("rd_after_err", 64'h8000_0018, 1'b1, last_rd);

    // mem_rdata holds across a write
    do_write("wr_hold", 64'h8000_0003, 64'hA5A5_5A5A_C3C3_3C3C, 8'hF0, 1'b0, 1'b1);
    check("rdata_hold", mem_rdata, last_rd);

    // Request with neither wen nor ren is ignored
    s_rdy = n_ready; s_v = n_aw_vcyc + n_ar_vcyc;
    mem_valid = 1'b1; mem_wen = 1'b0; mem_ren = 1'b0; mem_addr = 64'h8000_0010;
    repeat (4) @(posedge clk);
    #1;
    mem_valid = 1'b0;
    check("none_no_ready", 64'(n_ready - s_rdy), 64'd0);
    check("none_no_valid", 64'(n_aw_vcyc + n_ar_vcyc - s_v), 64'd0);
    check("none_states", {60'd0, debug_axi_wstate, debug_axi_rstate}, 64'd0);
    @(posedge clk); #1;

    // Randomized traffic against the reference memory
    for (int i = 0; i < 16; i++) begin
      op  = $urandom_range(0, 2);
      awd = $urandom_range(0, 3); wd = $urandom_range(0, 3); ard = $urandom_range(0, 3);
      bd  = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
      resp = ($urandom_range(0, 3) == 0) ? RESP_SLVERR : RESP_OKAY;
      if (op == 1) begin
        set_slave(awd, wd, ard, bd, rdl, RESP_OKAY, resp);
        do_read("rnd_rd", addrs[$urandom_range(0, 3)], (ard == 0) && (rdl == 0), rd);
      end else begin
        set_slave(awd, wd, ard, bd, rdl, resp, RESP_OKAY);
        do_write("rnd_wr", addrs[$urandom_range(0, 3)], {$urandom, $urandom}, 8'($urandom),
                 (op == 2), (awd == 0) && (wd == 0) && (bd == 0));
      end
    end

    // Asynchronous reset while waiting for the write response
    set_slave(0, 0, 0, 30, 0, RESP_OKAY, RESP_OKAY);
    mem_valid = 1'b1; mem_wen = 1'b1; mem_ren = 1'b0;
    mem_addr = 64'h8000_0010; mem_wdata = 64'h0BAD_F00D_0BAD_F00D; mem_wmask = 8'hFF;
    reached = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!reached) begin
        @(posedge clk); #1;
        if (debug_axi_wstate == 2'd2) reached = 1'b1;
      end
    end
    mem_valid = 1'b0; mem_wen = 1'b0;
    check("rstmid_reached_wresp", {63'd0, reached}, 64'd1);
    check("rstmid_b_ready_before", {63'd0, axi.b_ready}, 64'd1);
    s_rdy = n_ready;
    #2 rstn = 1'b0;
    #1;
    check("rstmid_async_valids", {59'd0, axi.aw_valid, axi.w_valid, axi.b_ready, axi.ar_valid, axi.r_ready}, 64'd0);
    check("rstmid_async_ready_err", {62'd0, mem_ready, mem_error}, 64'd0);
    check("rstmid_async_wstate", {62'd0, debug_axi_wstate}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    set_slave(0, 0, 0, 0, 0, RESP_OKAY, RESP_OKAY);
    repeat (5) @(posedge clk);
    #1;
    check("rstmid_no_pulse", 64'(n_ready - s_rdy), 64'd0);
    check("rstmid_wstate_after", {62'd0, debug_axi_wstate}, 64'd0);
    check("rstmid_rdata_cleared", mem_rdata, 64'd0);
    do_read("rd_after_rst", 64'h8000_0010, 1'b1, rd);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
